fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer that drives the program counter (loadPC/incPC/address) and consumes its execadd output.
- Fetches one 8-bit instruction per PC value from instruction memory over a req/ack handshake.
- Holds the instruction in an internal IR and offers it to the execute stage with a valid/ready handshake.
- Applies redirects (jumps) and halt requests from execute; sits between the PC, instruction memory and the decoder/execute unit.

Parameters:
- ADDR_W, 6: program-counter and memory address width.
- DATA_W, 8: instruction width.
- RESET_VEC, 6'd0: address loaded into the PC after reset.
- TIMEOUT_CYC, 16: memory-ack timeout in cycles; used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- loadPC  out  1  one-cycle pulse; PC loads address at the next edge.
- incPC  out  1  one-cycle pulse; PC increments at the next edge.
- address  out  ADDR_W  load value for the PC.
- execadd  in  ADDR_W  current PC value.
- mem_req  out  1  fetch request; held until mem_ack.
- mem_addr  out  ADDR_W  fetch address; stable while mem_req=1.
- mem_ack  in  1  read data valid this cycle.
- mem_rdata  in  DATA_W  instruction data.
- ir  out  DATA_W  held instruction.
- ir_valid  out  1  ir offered to execute.
- exec_ready  in  1  execute accepts ir.
- redirect_valid  in  1  jump request, one cycle.
- redirect_addr  in  ADDR_W  jump target.
- halt_req  in  1  stop fetching.
- halted  out  1  block is in HALT or ERR.
- fetch_err  out  1  sticky timeout flag.

Behaviour:
- Clock and reset: one clock (clk); reset (rst_n) is asynchronous, active-low.
- Reset values: state=BOOT, all pulse outputs 0, mem_req=0, ir=0, ir_valid=0, halted=0, fetch_err=0, address=RESET_VEC.
- BOOT:
  - First cycle after reset release.
  - Pulse loadPC with address=RESET_VEC.
  - Next state is FETCH.
- FETCH:
  - mem_req=1 and mem_addr=execadd; execadd is captured into req_addr every cycle.
  - On mem_ack: ir<=mem_rdata, pulse incPC, go to ISSUE.
  - Zero-wait ack (in the first FETCH cycle) is legal.
- ISSUE:
  - ir_valid=1; ir is stable while ir_valid=1.
  - On exec_ready: go to FETCH. Minimum throughput is one instruction per 2 cycles.
  - incPC has already advanced the PC, so the next FETCH uses the new execadd.
- DRAIN:
  - Entered when a redirect or halt arrives in FETCH without a same-cycle ack.
  - mem_req=1 and mem_addr=req_addr (the old address) until mem_ack.
  - The acked data is discarded: no IR load, no incPC.
  - Then go to HALT if halt_pend=1, else to FETCH.
- Redirect:
  - Pulse loadPC with address=redirect_addr in the same cycle.
  - In ISSUE: drop ir_valid, go to FETCH.
  - In FETCH with ack that cycle: data discarded, no incPC, go to FETCH.
  - In FETCH without ack: go to DRAIN.
  - In DRAIN: loadPC again; the latest redirect wins.
  - In BOOT: the redirect overrides RESET_VEC.
- Simultaneous events:
  - redirect_valid together with exec_ready in ISSUE: the instruction counts as accepted and the redirect is applied.
  - halt_req together with redirect_valid: halt wins, no loadPC.
- Halt:
  - Sampled in any state.
  - With memory outstanding (FETCH without ack, or DRAIN): set halt_pend and drain first.
  - Otherwise go directly to HALT.
- HALT:
  - mem_req=0, ir_valid=0, halted=1.
  - Redirects are ignored; exit only via rst_n.
- PC wrap (63 to 0) is the PC's responsibility and is transparent here.
- Reset mid-transaction: all state clears immediately. Memory must tolerate a dropped mem_req.
- Invariants:
  - loadPC and incPC are never both 1.
  - mem_req never drops before mem_ack, except on reset or ERR.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- With the macro:
  - Counter runs while mem_req=1 and mem_ack=0; it clears on ack or on a new request.
  - When the count reaches TIMEOUT_CYC: go to ERR, set mem_req=0, fetch_err=1 (sticky), halted=1.
  - ERR exits only via reset.
- Without the macro: no counter, fetch_err tied to 0, the block waits for mem_ack indefinitely.

Decomposition:
- Package fetch_pkg holds:
  - the state enum: BOOT, FETCH, ISSUE, DRAIN, HALT, ERR;
  - ADDR_W and DATA_W default constants;
  - the RESET_VEC default.
- Sub-module fetch_timeout: a saturating counter with clear/enable and an expire output, instantiated only under FETCH_TIMEOUT_EN.

Test Plan:
1. Reset release, memory acks with 2-cycle latency, returning data = addr^8'hA5, exec_ready=1 → loadPC pulse with address=0, then IR sequence A5, A4, A7, each IR load accompanied by an incPC pulse.
2. exec_ready held 0 for 5 cycles in ISSUE → ir_valid=1 and ir stable, mem_req=0, no incPC until ready.
3. Redirect to 6'd40 while mem_ack is pending for addr 3 → loadPC pulse with address=40, DRAIN keeps mem_addr=3, ack data discarded, next fetch at addr 40.
4. Redirect and halt_req in the same ISSUE cycle → no loadPC, halted=1, mem_req stays 0 afterwards.
5. PC at 63, fetch acked → incPC issued, next mem_addr=0.
6. With FETCH_TIMEOUT_EN, TIMEOUT_CYC=16, mem_ack never asserted → fetch_err=1 and mem_req=0 exactly 16 cycles after mem_req rose. Without the macro → mem_req stays high and fetch_err=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int ADDR_W_DEF      = 6;
    localparam int DATA_W_DEF      = 8;
    localparam int RESET_VEC_DEF   = 0;
    localparam int TIMEOUT_CYC_DEF = 16;

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        HALT  = 3'd4,
        ERR   = 3'd5
    } fetch_state_e;

endpackage

// File: rtl/fetch_timeout.sv
// Saturating wait counter for an outstanding memory request; expire fires on
// the cycle whose clock edge would bring the count to LIMIT.
module fetch_timeout #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_W'(LIMIT))) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire = enable && !clear && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer between the PC, instruction memory and execute.
// Optional memory-ack timeout is enabled with FETCH_TIMEOUT_EN.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF)
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              loadPC,
    output logic              incPC,
    output logic [ADDR_W-1:0] address,
    input  logic [ADDR_W-1:0] execadd,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    input  logic              exec_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              halt_req,
    output logic              halted,
    output logic              fetch_err,
    output fetch_state_e      dbg_state
);

    fetch_state_e      state, state_nx;
    logic              halt_pend, halt_pend_nx;
    logic              load_ir;
    logic              expire;
    logic [ADDR_W-1:0] req_addr;

`ifdef FETCH_TIMEOUT_EN
    fetch_timeout #(.LIMIT(TIMEOUT_CYC)) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (mem_ack || !mem_req),
        .enable (mem_req),
        .expire (expire)
    );
    assign fetch_err = (state == ERR);
`else
    assign expire    = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BOOT;
            halt_pend <= 1'b0;
            ir        <= '0;
            req_addr  <= RESET_VEC;
        end else begin
            state     <= state_nx;
            halt_pend <= halt_pend_nx;
            if (load_ir) ir <= mem_rdata;
            if (state == FETCH) req_addr <= execadd;
        end
    end

    // Handshakes: mem_req/mem_addr are held until the cycle mem_ack=1; ir is
    // held while ir_valid=1 and transfers on a cycle with ir_valid && exec_ready.
    always_comb begin
        state_nx     = state;
        halt_pend_nx = halt_pend;
        load_ir      = 1'b0;
        loadPC       = 1'b0;
        incPC        = 1'b0;
        address      = RESET_VEC;
        mem_req      = 1'b0;
        mem_addr     = execadd;
        ir_valid     = 1'b0;
        case (state)
            BOOT: begin
                if (halt_req) begin
                    state_nx = HALT;
                end else begin
                    // BOOT is also the state held during reset; keep the pulse quiet there.
                    loadPC   = rst_n;
                    address  = redirect_valid ? redirect_addr : RESET_VEC;
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                mem_req = 1'b1;
                if (expire) begin
                    state_nx = ERR;
                end else if (halt_req) begin
                    if (mem_ack) begin
                        state_nx = HALT;
                    end else begin
                        halt_pend_nx = 1'b1;
                        state_nx     = DRAIN;
                    end
                end else if (redirect_valid) begin
                    loadPC   = 1'b1;
                    address  = redirect_addr;
                    state_nx = mem_ack ? FETCH : DRAIN;
                end else if (mem_ack) begin
                    load_ir  = 1'b1;
                    incPC    = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                ir_valid = 1'b1;
                if (halt_req) begin
                    state_nx = HALT;
                end else if (redirect_valid) begin
                    loadPC   = 1'b1;
                    address  = redirect_addr;
                    state_nx = FETCH;
                end else if (exec_ready) begin
                    state_nx = FETCH;
                end
            end
            DRAIN: begin
                mem_req  = 1'b1;
                mem_addr = req_addr;
                if (expire) begin
                    state_nx = ERR;
                end else begin
                    if (halt_req) begin
                        halt_pend_nx = 1'b1;
                    end else if (redirect_valid && !halt_pend) begin
                        loadPC  = 1'b1;
                        address = redirect_addr;
                    end
                    if (mem_ack) state_nx = (halt_pend || halt_req) ? HALT : FETCH;
                end
            end
            HALT:    state_nx = HALT;
            ERR:     state_nx = ERR;
            default: state_nx = BOOT;
        endcase
    end

    assign halted    = (state == HALT) || (state == ERR);
    assign dbg_state = state;

endmodule
